// File: rtl/pcie_rx_detect_seq_if.sv
// Signal bundle between the receiver-detect sequencer, the LTSSM controller
// and the PHY receiver-detect port. The sequencer uses the slave view and the
// environment (controller + PHY side) uses the master view.
interface pcie_rx_detect_seq_if #(
    parameter int NUM_LANES = 1
);
    logic                 start_i;
    logic [NUM_LANES-1:0] elec_idle_exit_i;
    logic                 rxdet_req_o;
    logic                 rxdet_ack_i;
    logic [NUM_LANES-1:0] rxdet_result_i;
    logic [NUM_LANES-1:0] lane_detect_o;
    logic                 detect_done_o;
    logic                 active_o;

    modport slave (
        input  start_i,
        input  elec_idle_exit_i,
        input  rxdet_ack_i,
        input  rxdet_result_i,
        output rxdet_req_o,
        output lane_detect_o,
        output detect_done_o,
        output active_o
    );

    modport master (
        output start_i,
        output elec_idle_exit_i,
        output rxdet_ack_i,
        output rxdet_result_i,
        input  rxdet_req_o,
        input  lane_detect_o,
        input  detect_done_o,
        input  active_o
    );
endinterface

// File: rtl/pcie_rx_detect_seq.sv
// Receiver-detection sequencer for the LTSSM Detect.Quiet / Detect.Active
// substates. Waits out Detect.Quiet (or leaves early on electrical-idle exit),
// issues a receiver-detect request to the PHY, retries once after a quiet-length
// wait when only some lanes answered, and publishes the detected-lane mask to
// the controller. All outputs are registered.
module pcie_rx_detect_seq #(
    parameter int NUM_LANES       = 1,
    parameter int QUIET_CYC       = 1024,
    parameter int ACK_TIMEOUT_CYC = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pcie_rx_detect_seq_if.slave  bus
);

    localparam int MAX_CYC = (QUIET_CYC > ACK_TIMEOUT_CYC) ? QUIET_CYC : ACK_TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_QUIET      = 3'd1,
        ST_ACTIVE1    = 3'd2,
        ST_RETRY_WAIT = 3'd3,
        ST_ACTIVE2    = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

    // Saturating increment: the timing counter must never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    state_e               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 req_r, req_s;
    logic [NUM_LANES-1:0] res1_r, res1_s;
    logic [NUM_LANES-1:0] lane_r, lane_s;
    logic                 done_r, done_s;
    logic                 active_r, active_s;
    logic                 ack_s;

    // An acknowledge only counts while a request is actually outstanding.
    assign ack_s = bus.rxdet_ack_i & req_r;

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            req_r    <= 1'b0;
            res1_r   <= {NUM_LANES{1'b0}};
            lane_r   <= {NUM_LANES{1'b0}};
            done_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            req_r    <= req_s;
            res1_r   <= res1_s;
            lane_r   <= lane_s;
            done_r   <= done_s;
            active_r <= active_s;
        end
    end

    // Next-state and next-output decode; dropping start_i overrides everything,
    // including an acknowledge arriving in the same cycle.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        req_s   = req_r;
        res1_s  = res1_r;
        lane_s  = lane_r;
        done_s  = 1'b0;

        if (!bus.start_i) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            req_s   = 1'b0;
            lane_s  = {NUM_LANES{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_QUIET;
                    cnt_s   = CNT_ZERO;
                end

                ST_QUIET: begin
                    if ((cnt_r == QUIET_LAST) || (|bus.elec_idle_exit_i)) begin
                        state_s = ST_ACTIVE1;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = sat_inc(cnt_r);
                    end
                end

                ST_ACTIVE1, ST_ACTIVE2: begin
                    if (!req_r) begin
                        // First cycle in the state: raise the request. The ack
                        // timeout is measured from here on.
                        req_s = 1'b1;
                        cnt_s = CNT_ZERO;
                    end else if (ack_s) begin
                        req_s = 1'b0;
                        cnt_s = CNT_ZERO;
                        if (state_r == ST_ACTIVE1) begin
                            if (&bus.rxdet_result_i) begin
                                state_s = ST_DONE;
                                lane_s  = bus.rxdet_result_i;
                                done_s  = 1'b1;
                            end else if (~|bus.rxdet_result_i) begin
                                state_s = ST_QUIET;
                            end else begin
                                // Partial detect: remember it and confirm later.
                                state_s = ST_RETRY_WAIT;
                                res1_s  = bus.rxdet_result_i;
                            end
                        end else begin
                            if (bus.rxdet_result_i == res1_r) begin
                                state_s = ST_DONE;
                                lane_s  = res1_r;
                                done_s  = 1'b1;
                            end else begin
                                state_s = ST_QUIET;
                            end
                        end
                    end else if (cnt_r == ACK_LAST) begin
                        // PHY never answered: same as nothing detected.
                        req_s   = 1'b0;
                        cnt_s   = CNT_ZERO;
                        state_s = ST_QUIET;
                    end else begin
                        cnt_s = sat_inc(cnt_r);
                    end
                end

                ST_RETRY_WAIT: begin
                    if (cnt_r == QUIET_LAST) begin
                        state_s = ST_ACTIVE2;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = sat_inc(cnt_r);
                    end
                end

                ST_DONE: begin
                    state_s = ST_DONE;
                end

                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    req_s   = 1'b0;
                    lane_s  = {NUM_LANES{1'b0}};
                end
            endcase
        end

        active_s = (state_s == ST_ACTIVE1) || (state_s == ST_ACTIVE2) ||
                   (state_s == ST_RETRY_WAIT);
    end

    assign bus.rxdet_req_o   = req_r;
    assign bus.lane_detect_o = lane_r;
    assign bus.detect_done_o = done_r;
    assign bus.active_o      = active_r;

endmodule

// File: tb/tb_pcie_rx_detect_seq.sv
// Self-checking bench for pcie_rx_detect_seq. Each detect attempt is described
// by a few choices (early idle exit, ack delay or timeout, PHY result, abort),
// and the expected per-cycle outputs follow from the protocol timing:
// quiet length, one cycle before the request rises, at most ACK cycles of
// request, then the retry / done / quiet decision.
module tb_pcie_rx_detect_seq;

    localparam int NL = 4;
    localparam int QC = 16;
    localparam int AT = 8;

    localparam int OUT_QUIET = 0;
    localparam int OUT_RETRY = 1;
    localparam int OUT_DONE  = 2;
    localparam int OUT_IDLE  = 3;

    logic clk;
    logic rst_n;

    pcie_rx_detect_seq_if #(.NUM_LANES(NL)) bus ();

    pcie_rx_detect_seq #(
        .NUM_LANES      (NL),
        .QUIET_CYC      (QC),
        .ACK_TIMEOUT_CYC(AT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic          e_req;
    logic          e_act;
    logic          e_done;
    logic [NL-1:0] e_lane;
    logic [NL-1:0] res1_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare all outputs.
    task automatic cyc();
        @(negedge clk);
        check_val("rxdet_req",   32'(bus.rxdet_req_o),   32'(e_req));
        check_val("active",      32'(bus.active_o),      32'(e_act));
        check_val("detect_done", 32'(bus.detect_done_o), 32'(e_done));
        check_val("lane_detect", 32'(bus.lane_detect_o), 32'(e_lane));
    endtask

    // Quiet (or retry-wait) period, entered at the current falling edge.
    task automatic quiet_phase(input bit retry, input int early);
        int n;
        n = (!retry && early >= 0) ? early : QC - 1;
        for (int j = 0; j <= n; j++) begin
            if (retry) bus.elec_idle_exit_i = NL'($urandom);
            else if (j == early) bus.elec_idle_exit_i = NL'($urandom_range(1, (1 << NL) - 1));
            else bus.elec_idle_exit_i = '0;
            bus.rxdet_ack_i    = 1'($urandom);
            bus.rxdet_result_i = NL'($urandom);
            e_req  = 1'b0;
            e_done = 1'b0;
            e_act  = (j == n) ? 1'b1 : retry;
            cyc();
        end
    endtask

    // Request/acknowledge exchange; d < 0 means the PHY never answers.
    task automatic handshake(input bit second, input int d, input logic [NL-1:0] res,
                             input int abort_k, output int outcome);
        bus.rxdet_ack_i      = 1'b0;
        bus.elec_idle_exit_i = NL'($urandom);
        e_req = 1'b1; e_act = 1'b1; e_done = 1'b0;
        cyc();
        outcome = OUT_QUIET;
        for (int k = 0; k < AT; k++) begin
            bus.elec_idle_exit_i = NL'($urandom);
            if (k == abort_k) begin
                bus.start_i        = 1'b0;
                bus.rxdet_ack_i    = 1'b1;
                bus.rxdet_result_i = '1;
                e_req = 1'b0; e_act = 1'b0; e_done = 1'b0; e_lane = '0;
                cyc();
                outcome = OUT_IDLE;
                return;
            end
            if (k == d) begin
                bus.rxdet_ack_i    = 1'b1;
                bus.rxdet_result_i = res;
                e_req = 1'b0;
                if (!second) begin
                    if (res == '1) outcome = OUT_DONE;
                    else if (res == '0) outcome = OUT_QUIET;
                    else begin outcome = OUT_RETRY; res1_m = res; end
                end else begin
                    outcome = (res == res1_m) ? OUT_DONE : OUT_QUIET;
                end
                e_act  = (outcome == OUT_RETRY);
                e_done = (outcome == OUT_DONE);
                if (outcome == OUT_DONE) e_lane = second ? res1_m : res;
                cyc();
                bus.rxdet_ack_i = 1'b0;
                e_done = 1'b0;
                return;
            end
            bus.rxdet_ack_i    = 1'b0;
            bus.rxdet_result_i = NL'($urandom);
            if (k == AT - 1) begin
                e_req = 1'b0; e_act = 1'b0;
                outcome = OUT_QUIET;
            end else begin
                e_req = 1'b1; e_act = 1'b1;
            end
            cyc();
        end
    endtask

    task automatic start_seq(input int idle_cycles);
        bus.start_i = 1'b0;
        e_req = 1'b0; e_act = 1'b0; e_done = 1'b0; e_lane = '0;
        for (int i = 0; i < idle_cycles; i++) begin
            bus.rxdet_ack_i = 1'($urandom);
            cyc();
        end
        bus.start_i     = 1'b1;
        bus.rxdet_ack_i = 1'b0;
        cyc();
    endtask

    task automatic done_hold(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rxdet_ack_i      = 1'($urandom);
            bus.rxdet_result_i   = NL'($urandom);
            bus.elec_idle_exit_i = NL'($urandom);
            e_req = 1'b0; e_act = 1'b0; e_done = 1'b0;
            cyc();
        end
    endtask

    task automatic stop_seq();
        bus.start_i     = 1'b0;
        bus.rxdet_ack_i = 1'($urandom);
        e_req = 1'b0; e_act = 1'b0; e_done = 1'b0; e_lane = '0;
        cyc();
        bus.rxdet_ack_i = 1'b0;
        cyc();
    endtask

    task automatic random_episode();
        int outcome, early, d, abort_k, pick;
        bit second;
        logic [NL-1:0] res;
        start_seq($urandom_range(0, 3));
        second = 1'b0;
        for (int a = 0; a < 6; a++) begin
            early = (!second && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, QC - 1)) : -1;
            quiet_phase(second, early);
            d       = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, AT - 1));
            abort_k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, AT - 1)) : -1;
            pick    = $urandom_range(0, 3);
            if (second) res = ($urandom_range(0, 1) == 0) ? res1_m : NL'($urandom);
            else if (pick == 0) res = '1;
            else if (pick == 1) res = '0;
            else res = NL'($urandom_range(1, (1 << NL) - 2));
            handshake(second, d, res, abort_k, outcome);
            if (outcome == OUT_IDLE) begin stop_seq(); return; end
            if (outcome == OUT_DONE) begin done_hold($urandom_range(1, 5)); stop_seq(); return; end
            second = (outcome == OUT_RETRY);
        end
        stop_seq();
    endtask

    initial begin
        int o;
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.elec_idle_exit_i = '0;
        bus.rxdet_ack_i = 1'b0; bus.rxdet_result_i = '0;
        e_req = 1'b0; e_act = 1'b0; e_done = 1'b0; e_lane = '0; res1_m = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Full detection after a complete quiet period.
        start_seq(1);
        quiet_phase(1'b0, -1);
        handshake(1'b0, 3, 4'b1111, -1, o);
        done_hold(3);
        stop_seq();

        // Early electrical-idle exit on the third quiet cycle.
        start_seq(0);
        quiet_phase(1'b0, 2);
        handshake(1'b0, 0, 4'b1111, -1, o);
        stop_seq();

        // Partial detect confirmed on retry.
        start_seq(0);
        quiet_phase(1'b0, -1);
        handshake(1'b0, 1, 4'b0011, -1, o);
        quiet_phase(1'b1, -1);
        handshake(1'b1, 2, 4'b0011, -1, o);
        done_hold(2);
        stop_seq();

        // Partial detect not confirmed, then nothing, then an ack timeout.
        start_seq(0);
        quiet_phase(1'b0, -1);
        handshake(1'b0, 0, 4'b0011, -1, o);
        quiet_phase(1'b1, -1);
        handshake(1'b1, 5, 4'b0001, -1, o);
        quiet_phase(1'b0, -1);
        handshake(1'b0, 7, 4'b0000, -1, o);
        quiet_phase(1'b0, -1);
        handshake(1'b0, -1, 4'b1111, -1, o);
        quiet_phase(1'b0, -1);
        stop_seq();

        // start_i dropped while the request is up, ack in the same cycle.
        start_seq(0);
        quiet_phase(1'b0, -1);
        handshake(1'b0, -1, 4'b1111, 4, o);
        stop_seq();

        // Asynchronous reset while in DONE.
        start_seq(0);
        quiet_phase(1'b0, 5);
        handshake(1'b0, 2, 4'b1111, -1, o);
        done_hold(2);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_req",   32'(bus.rxdet_req_o),   32'd0);
        check_val("async_rst_lane",  32'(bus.lane_detect_o), 32'd0);
        check_val("async_rst_done",  32'(bus.detect_done_o), 32'd0);
        check_val("async_rst_act",   32'(bus.active_o),      32'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst_n = 1'b1;
        e_req = 1'b0; e_act = 1'b0; e_done = 1'b0; e_lane = '0;
        cyc();

        for (int ep = 0; ep < 30; ep++) random_episode();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
